// File: rtl/universal_shift_reg.sv
// Universal shift register: hold, shift L/R, parallel load, soft clear, fill count.
// Define USR_ROTATE_EN to enable the rotate modes (101/110); otherwise they hold.
module universal_shift_reg #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   clear,
    input  logic                   en,
    input  logic [2:0]             mode,
    input  logic [WIDTH-1:0]       si_r,
    input  logic [WIDTH-1:0]       si_l,
    input  logic [WIDTH*DEPTH-1:0] pi,
    output logic [WIDTH-1:0]       so_l,
    output logic [WIDTH-1:0]       so_r,
    output logic [WIDTH*DEPTH-1:0] po,
    output logic [CW-1:0]          fill_cnt,
    output logic                   full
);

    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stg;
    logic [DEPTH-1:0][WIDTH-1:0] stg_nxt;
    logic [CW-1:0]               cnt;
    logic [CW-1:0]               cnt_nxt;
    logic [CW-1:0]               cnt_inc;

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

    always_comb begin
        stg_nxt = stg;
        cnt_nxt = cnt;
        if (en) begin
            unique case (mode)
                3'b001: begin
                    stg_nxt = {stg[DEPTH-2:0], si_r};
                    cnt_nxt = cnt_inc;
                end
                3'b010: begin
                    stg_nxt = {si_l, stg[DEPTH-1:1]};
                    cnt_nxt = cnt_inc;
                end
                3'b011: begin
                    stg_nxt = pi;
                    cnt_nxt = CNT_MAX;
                end
                3'b100: begin
                    stg_nxt = '0;
                    cnt_nxt = '0;
                end
`ifdef USR_ROTATE_EN
                3'b101: stg_nxt = {stg[DEPTH-2:0], stg[DEPTH-1]};
                3'b110: stg_nxt = {stg[0], stg[DEPTH-1:1]};
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            stg <= '0;
            cnt <= '0;
        end else begin
            stg <= stg_nxt;
            cnt <= cnt_nxt;
        end
    end

    assign so_l     = stg[DEPTH-1];
    assign so_r     = stg[0];
    assign po       = stg;
    assign fill_cnt = cnt;
    assign full     = (cnt == CNT_MAX);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg (WIDTH=1, DEPTH=8).
// Expectations for mode 101/110 follow USR_ROTATE_EN.
module tb_universal_shift_reg;

    logic       clk;
    logic       clear;
    logic       en;
    logic [2:0] mode;
    logic       si_r;
    logic       si_l;
    logic [7:0] pi;
    logic       so_l;
    logic       so_r;
    logic [7:0] po;
    logic [3:0] fill_cnt;
    logic       full;

    int passed;
    int total;

    universal_shift_reg #(.WIDTH(1), .DEPTH(8)) dut (
        .clk(clk), .clear(clear), .en(en), .mode(mode),
        .si_r(si_r), .si_l(si_l), .pi(pi),
        .so_l(so_l), .so_r(so_r), .po(po),
        .fill_cnt(fill_cnt), .full(full)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] v);
        clear = 0; en = 1; mode = 3'b011; pi = v;
        step();
    endtask

    task automatic test_reset();
        clear = 1; en = 0; mode = 3'b000;
        step();
        clear = 0;
        total++;
        if (po !== 8'h00 || so_l !== 1'b0 || so_r !== 1'b0)
            $display("FAIL reset_data po=%h so_l=%b so_r=%b want 00/0/0", po, so_l, so_r);
        else passed++;
        total++;
        if (fill_cnt !== 4'd0 || full !== 1'b0)
            $display("FAIL reset_cnt fill=%0d full=%b want 0/0", fill_cnt, full);
        else passed++;
    endtask

    task automatic test_shift_left();
        logic [4:0] seq;
        seq = 5'b10010;
        en = 1; mode = 3'b001;
        for (int i = 4; i >= 0; i--) begin
            si_r = seq[i];
            step();
        end
        total++;
        if (po[4:0] !== 5'b10010 || fill_cnt !== 4'd5 || full !== 1'b0)
            $display("FAIL shl_5 po=%b fill=%0d full=%b want 10010/5/0", po[4:0], fill_cnt, full);
        else passed++;
        si_r = 0;
        for (int i = 0; i < 3; i++) step();
        total++;
        if (so_l !== 1'b1 || fill_cnt !== 4'd8 || full !== 1'b1)
            $display("FAIL shl_8 so_l=%b fill=%0d full=%b want 1/8/1", so_l, fill_cnt, full);
        else passed++;
        total++;
        if (po !== 8'h90)
            $display("FAIL shl_po po=%h want 90", po);
        else passed++;
        step();
        total++;
        if (po !== 8'h20 || so_l !== 1'b0 || fill_cnt !== 4'd8)
            $display("FAIL shl_sat po=%h so_l=%b fill=%0d want 20/0/8", po, so_l, fill_cnt);
        else passed++;
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_sor;
        exp_sor = 8'hA5;
        load(8'hA5);
        total++;
        if (po !== 8'hA5 || fill_cnt !== 4'd8 || full !== 1'b1)
            $display("FAIL load po=%h fill=%0d full=%b want a5/8/1", po, fill_cnt, full);
        else passed++;
        mode = 3'b010; si_l = 0;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (so_r !== exp_sor[i])
                $display("FAIL shr_so_r[%0d] got %b want %b", i, so_r, exp_sor[i]);
            else passed++;
            step();
        end
        total++;
        if (po !== 8'h00)
            $display("FAIL shr_final po=%h want 00", po);
        else passed++;
    endtask

    task automatic test_hold();
        logic [5:0] seq;
        seq = 6'b111100;
        en = 1; mode = 3'b100;
        step();
        total++;
        if (po !== 8'h00 || fill_cnt !== 4'd0 || full !== 1'b0)
            $display("FAIL soft_clr po=%h fill=%0d full=%b want 00/0/0", po, fill_cnt, full);
        else passed++;
        mode = 3'b001;
        for (int i = 5; i >= 0; i--) begin
            si_r = seq[i];
            step();
        end
        total++;
        if (po !== 8'h3C || fill_cnt !== 4'd6)
            $display("FAIL build_3c po=%h fill=%0d want 3c/6", po, fill_cnt);
        else passed++;
        en = 0; mode = 3'b001; si_r = 1;
        for (int i = 0; i < 4; i++) step();
        total++;
        if (po !== 8'h3C || fill_cnt !== 4'd6)
            $display("FAIL en0_hold po=%h fill=%0d want 3c/6", po, fill_cnt);
        else passed++;
        en = 1; mode = 3'b000;
        step();
        mode = 3'b111;
        step();
        total++;
        if (po !== 8'h3C || fill_cnt !== 4'd6)
            $display("FAIL mode_hold po=%h fill=%0d want 3c/6", po, fill_cnt);
        else passed++;
    endtask

    task automatic test_clear_mid();
        en = 1; mode = 3'b001; si_r = 1;
        step();
        step();
        clear = 1; mode = 3'b011; pi = 8'hFF;
        step();
        total++;
        if (po !== 8'h00 || fill_cnt !== 4'd0 || full !== 1'b0)
            $display("FAIL clr_mid po=%h fill=%0d full=%b want 00/0/0", po, fill_cnt, full);
        else passed++;
        clear = 0; mode = 3'b001; si_r = 1;
        step();
        total++;
        if (po !== 8'h01 || fill_cnt !== 4'd1)
            $display("FAIL after_clr po=%h fill=%0d want 01/1", po, fill_cnt);
        else passed++;
    endtask

    task automatic test_xprop();
        logic [7:0] exp;
        exp = 8'b0000_000x;
        en = 1; mode = 3'b100;
        step();
        mode = 3'b001; si_r = 1'bx;
        step();
        si_r = 0;
        total++;
        if (po !== exp)
            $display("FAIL xprop po=%b want %b", po, exp);
        else passed++;
    endtask

    task automatic test_rotate();
        logic [7:0] exp_l;
        logic [7:0] exp_r;
`ifdef USR_ROTATE_EN
        exp_l = 8'h03;
        exp_r = 8'h81;
`else
        exp_l = 8'h81;
        exp_r = 8'h81;
`endif
        load(8'h81);
        mode = 3'b101;
        step();
        total++;
        if (po !== exp_l || fill_cnt !== 4'd8)
            $display("FAIL rotl po=%h fill=%0d want %h/8", po, fill_cnt, exp_l);
        else passed++;
        mode = 3'b110;
        step();
        total++;
        if (po !== exp_r || fill_cnt !== 4'd8)
            $display("FAIL rotr po=%h fill=%0d want %h/8", po, fill_cnt, exp_r);
        else passed++;
        load(8'h01);
        mode = 3'b110;
        step();
        total++;
`ifdef USR_ROTATE_EN
        if (po !== 8'h80)
            $display("FAIL rotr_wrap po=%h want 80", po);
        else passed++;
`else
        if (po !== 8'h01)
            $display("FAIL rotr_wrap po=%h want 01", po);
        else passed++;
`endif
    endtask

    initial begin
        passed = 0; total = 0;
        clear = 0; en = 0; mode = 3'b000;
        si_r = 0; si_l = 0; pi = 8'h00;
        test_reset();
        test_shift_left();
        test_shift_right();
        test_hold();
        test_clear_mid();
        test_xprop();
        test_rotate();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
